// File: rtl/fpu_i2f_writeback.sv
// Writeback buffer for the int-to-float converter: queues results, NaN-boxes them
// into the FP register file, accumulates fflags and counts retired results.
module fpu_i2f_writeback #(
    parameter int STD   = 15,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [STD:0]   in_float,
    input  logic [4:0]     in_rd,
    input  logic           in_invalid,
    input  logic           in_inexact,
    input  logic           flush,
    input  logic           wb_stall,
    output logic           wb_en,
    output logic [4:0]     wb_addr,
    output logic [31:0]    wb_data,
    input  logic           csr_wr,
    input  logic [4:0]     csr_wdata,
    output logic [4:0]     fflags,
    output logic [15:0]    retire_cnt
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = STD + 1 + 5 + 2;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] entry_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [4:0]         fflags_reg, fflags_next;
    logic [15:0]        retire_reg, retire_next;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [STD:0]       head_float;
    logic [4:0]         head_rd;
    logic               head_invalid;
    logic               head_inexact;
    logic [4:0]         pop_flags;

    assign head_entry   = entry_reg[rd_ptr_reg];
    assign head_float   = head_entry[ENTRY_W-1 -: STD+1];
    assign head_rd      = head_entry[6:2];
    assign head_invalid = head_entry[1];
    assign head_inexact = head_entry[0];

    assign in_ready = (count_reg < DEPTH_CNT) && !flush;
    assign push     = in_valid && in_ready;
    assign wb_en    = (count_reg != '0) && !wb_stall && !flush;
    assign pop      = wb_en;

    // Single-precision NaN-boxing: upper bits all ones above the narrow result
    assign wb_addr    = head_rd;
    assign wb_data    = {{(31-STD){1'b1}}, head_float};
    assign fflags     = fflags_reg;
    assign retire_cnt = retire_reg;

    // Only the retiring head contributes flags; DZ/OF/UF are CSR-only
    assign pop_flags = pop ? {head_invalid, 3'b000, head_inexact} : 5'b00000;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        fflags_next = fflags_reg | pop_flags;
        if (csr_wr) begin
            fflags_next = csr_wdata | pop_flags;
        end
        retire_next = retire_reg + {15'd0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            fflags_reg <= '0;
            retire_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            fflags_reg <= fflags_next;
            retire_reg <= retire_next;
        end
    end

    // Payload storage needs no reset: occupancy count qualifies every entry
    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[wr_ptr_reg] <= {in_float, in_rd, in_invalid, in_inexact};
        end
    end

endmodule

// File: tb/tb_fpu_i2f_writeback.sv
// Randomised and directed bench for fpu_i2f_writeback against a queue-based
// reference model of the writeback buffer.
module tb_fpu_i2f_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_float = '0;
    logic [4:0]  in_rd = '0;
    logic        in_invalid = 1'b0;
    logic        in_inexact = 1'b0;
    logic        flush = 1'b0;
    logic        wb_stall = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        csr_wr = 1'b0;
    logic [4:0]  csr_wdata = '0;
    logic [4:0]  fflags;
    logic [15:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] f;
        logic [4:0]  rd;
        logic        inv;
        logic        inx;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  m_ff = '0;
    logic [15:0] m_ret = '0;
    logic        exp_ready;
    logic        exp_wb_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    fpu_i2f_writeback #(.STD(15), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_float(in_float),
        .in_rd(in_rd), .in_invalid(in_invalid), .in_inexact(in_inexact),
        .flush(flush), .wb_stall(wb_stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .csr_wr(csr_wr), .csr_wdata(csr_wdata),
        .fflags(fflags), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic calc_exp();
        exp_ready = (mq.size() < 2) && !flush;
        exp_wb_en = (mq.size() != 0) && !wb_stall && !flush;
        exp_addr  = (mq.size() != 0) ? mq[0].rd : 5'd0;
        exp_data  = (mq.size() != 0) ? {16'hFFFF, mq[0].f} : 32'd0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ff  = '0;
        m_ret = '0;
    endtask

    // Advance the model by one clock using the inputs present now, then step the DUT
    task automatic tick();
        ent_t       h;
        ent_t       n;
        logic [4:0] pf;
        calc_exp();
        pf = 5'd0;
        if (flush) begin
            mq.delete();
        end else begin
            if (exp_wb_en) begin
                h  = mq.pop_front();
                pf = {h.inv, 3'b000, h.inx};
                m_ret = m_ret + 16'd1;
            end
            if (in_valid && exp_ready) begin
                n.f = in_float; n.rd = in_rd; n.inv = in_invalid; n.inx = in_inexact;
                mq.push_back(n);
            end
        end
        m_ff = csr_wr ? (csr_wdata | pf) : (m_ff | pf);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_float = '0; in_rd = '0; in_invalid = 1'b0; in_inexact = 1'b0;
        flush = 1'b0; wb_stall = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", wb_en); end
        checks++; if (fflags !== 5'd0) begin errors++; $display("FAIL reset_fflags: got %b expected 00000", fflags); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_retire: got %0d expected 0", retire_cnt); end
        rst = 1'b0;
        model_reset();
        $display("reset: done");
    endtask

    task automatic test_single();
        idle_inputs();
        in_valid = 1'b1; in_float = 16'h4A00; in_rd = 5'd3;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", wb_en); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL single_wb_en: got %b expected 1", wb_en); end
        checks++; if (wb_addr !== 5'd3) begin errors++; $display("FAIL single_addr: got %0d expected 3", wb_addr); end
        checks++; if (wb_data !== 32'hFFFF4A00) begin errors++; $display("FAIL single_data: got %h expected FFFF4A00", wb_data); end
        tick();
        checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL single_retire: got %0d expected 1", retire_cnt); end
        checks++; if (fflags !== 5'd0) begin errors++; $display("FAIL single_fflags: got %b expected 00000", fflags); end
        $display("single: wb_addr=%0d wb_data=%h retire=%0d", 3, 32'hFFFF4A00, retire_cnt);
    endtask

    task automatic test_backpressure();
        idle_inputs();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_rd = 5'(5 + i); in_float = 16'($urandom);
            #1;
            checks++; if (in_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, (i < 2)); end
            checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL bp_stalled_wb_en[%0d]: got %b expected 0", i, wb_en); end
            tick();
        end
        in_valid = 1'b0; wb_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            calc_exp();
            checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL bp_drain_en[%0d]: got %b expected 1", i, wb_en); end
            checks++; if (wb_addr !== 5'(5 + i)) begin errors++; $display("FAIL bp_drain_addr[%0d]: got %0d expected %0d", i, wb_addr, 5 + i); end
            checks++; if (wb_data !== exp_data) begin errors++; $display("FAIL bp_drain_data[%0d]: got %h expected %h", i, wb_data, exp_data); end
            tick();
        end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL bp_empty_wb_en: got %b expected 0", wb_en); end
        $display("backpressure: 2 accepted, 1 refused, drained in order");
    endtask

    task automatic test_flags();
        idle_inputs();
        csr_wr = 1'b1; csr_wdata = 5'd0;
        tick();
        csr_wr = 1'b0;
        in_valid = 1'b1; in_invalid = 1'b1;
        tick();
        in_valid = 1'b0; in_invalid = 1'b0;
        tick();
        in_valid = 1'b1; in_inexact = 1'b1;
        tick();
        in_valid = 1'b0; in_inexact = 1'b0;
        tick();
        checks++; if (fflags !== 5'b10001) begin errors++; $display("FAIL flags_accum: got %b expected 10001", fflags); end
        in_valid = 1'b1; in_inexact = 1'b1;
        tick();
        in_valid = 1'b0; in_inexact = 1'b0;
        csr_wr = 1'b1; csr_wdata = 5'd0;
        tick();
        csr_wr = 1'b0;
        checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL flags_csr_retire: got %b expected 00001", fflags); end
        checks++; if (fflags !== m_ff) begin errors++; $display("FAIL flags_model: got %b expected %b", fflags, m_ff); end
        $display("flags: accumulate and same-cycle csr write, fflags=%b", fflags);
    endtask

    task automatic test_flush();
        logic [4:0] ff_before;
        idle_inputs();
        wb_stall = 1'b1;
        in_valid = 1'b1; in_invalid = 1'b1; in_float = 16'h1234; in_rd = 5'd9;
        tick();
        tick();
        ff_before = m_ff;
        flush = 1'b1; in_rd = 5'd10;
        #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en: got %b expected 0", wb_en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_empty_wb_en: got %b expected 0", wb_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_ready: got %b expected 1", in_ready); end
        checks++; if (fflags !== ff_before) begin errors++; $display("FAIL flush_fflags: got %b expected %b", fflags, ff_before); end
        tick();
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", wb_en); end
        $display("flush: buffer emptied, fflags=%b", fflags);
    endtask

    task automatic test_ptr_wrap();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_float = 16'($urandom); in_rd = 5'($urandom);
            #1;
            calc_exp();
            checks++; if (wb_en !== exp_wb_en) begin errors++; $display("FAIL wrap_wb_en[%0d]: got %b expected %b", i, wb_en, exp_wb_en); end
            if (exp_wb_en) begin
                checks++; if (wb_addr !== exp_addr || wb_data !== exp_data) begin errors++; $display("FAIL wrap_order[%0d]: got %0d/%h expected %0d/%h", i, wb_addr, wb_data, exp_addr, exp_data); end
            end
            $display("wrap: cycle %0d wb_en=%b addr=%0d data=%h", i, wb_en, wb_addr, wb_data);
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_float   = 16'($urandom);
            in_rd      = 5'($urandom);
            in_invalid = 1'($urandom_range(0, 1));
            in_inexact = 1'($urandom_range(0, 1));
            wb_stall   = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            csr_wr     = ($urandom_range(0, 15) == 0);
            csr_wdata  = 5'($urandom);
            #1;
            calc_exp();
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_ready); end
            checks++; if (wb_en !== exp_wb_en) begin errors++; $display("FAIL rnd_wb_en[%0d]: got %b expected %b", i, wb_en, exp_wb_en); end
            if (mq.size() != 0) begin
                checks++; if (wb_addr !== exp_addr || wb_data !== exp_data) begin errors++; $display("FAIL rnd_head[%0d]: got %0d/%h expected %0d/%h", i, wb_addr, wb_data, exp_addr, exp_data); end
            end
            checks++; if (fflags !== m_ff) begin errors++; $display("FAIL rnd_fflags[%0d]: got %b expected %b", i, fflags, m_ff); end
            checks++; if (retire_cnt !== m_ret) begin errors++; $display("FAIL rnd_retire[%0d]: got %0d expected %0d", i, retire_cnt, m_ret); end
            tick();
        end
        idle_inputs();
        $display("random: 300 cycles, fflags=%b retire=%0d", m_ff, m_ret);
    endtask

    task automatic test_retire_wrap();
        idle_inputs();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        checks++; if (retire_cnt !== 16'hFFFF) begin errors++; $display("FAIL retire_ffff: got %h expected FFFF", retire_cnt); end
        in_valid = 1'b0;
        tick();
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL retire_wrap: got %h expected 0000", retire_cnt); end
        checks++; if (retire_cnt !== m_ret) begin errors++; $display("FAIL retire_model: got %h expected %h", retire_cnt, m_ret); end
        $display("retire_wrap: 65536 retires, retire_cnt=%h", retire_cnt);
    endtask

    task automatic test_async_reset();
        idle_inputs();
        wb_stall = 1'b1;
        in_valid = 1'b1; in_invalid = 1'b1; in_rd = 5'd17; in_float = 16'hBEEF;
        csr_wr = 1'b1; csr_wdata = 5'h1F;
        tick();
        idle_inputs();
        #1;
        checks++; if (wb_en !== 1'b1 || fflags !== 5'h1F) begin errors++; $display("FAIL areset_pre: got %b/%b expected 1/11111", wb_en, fflags); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL areset_wb_en: got %b expected 0", wb_en); end
        checks++; if (fflags !== 5'd0) begin errors++; $display("FAIL areset_fflags: got %b expected 00000", fflags); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL areset_retire: got %0d expected 0", retire_cnt); end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL areset_release_wb_en: got %b expected 0", wb_en); end
        @(posedge clk);
        #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL areset_next_wb_en: got %b expected 0", wb_en); end
        $display("async_reset: entry dropped, fflags=%b", fflags);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flags();
        test_flush();
        test_ptr_wrap();
        test_random();
        test_retire_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_i2f_writeback.md
FPU_I2F_WRITEBACK -- requirements
Module: fpu_i2f_writeback

Interface
REQ-001 SHALL have parameter STD, default 15, giving the converter result MSB index (result width STD+1).
REQ-002 SHALL have parameter DEPTH, default 2, giving the result-buffer entry count; only 2 is required to be supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  converter result present.
REQ-006 in_ready  output  1  buffer can accept a result.
REQ-007 in_float  input  STD+1  converted float from the int-to-float stage.
REQ-008 in_rd  input  5  destination FP register index.
REQ-009 in_invalid  input  1  converter invalid flag.
REQ-010 in_inexact  input  1  converter inexact flag.
REQ-011 flush  input  1  discard all buffered results.
REQ-012 wb_stall  input  1  FP register-file write port busy.
REQ-013 wb_en  output  1  register-file write strobe.
REQ-014 wb_addr  output  5  register-file write index.
REQ-015 wb_data  output  32  NaN-boxed write data.
REQ-016 csr_wr  input  1  fflags CSR write strobe.
REQ-017 csr_wdata  input  5  fflags write value {NV,DZ,OF,UF,NX}.
REQ-018 fflags  output  5  accumulated exception flags.
REQ-019 retire_cnt  output  16  count of results written back.

Function
REQ-020 SHALL hold results in a FIFO of DEPTH entries {float, rd, invalid, inexact}, using read/write pointers and an occupancy count.
REQ-021 SHALL drive in_ready = (count < DEPTH) and not flush; a push occurs when in_valid and in_ready are both high.
REQ-022 SHALL NOT bypass: a result pushed in cycle N is first visible on wb_* in cycle N+1 (latency 1).
REQ-023 SHALL drive wb_en = (count != 0) and not wb_stall and not flush, combinationally; a pop occurs exactly when wb_en is high.
REQ-024 SHALL drive wb_addr = head rd and wb_data = {(31-STD) ones, head float}; both SHALL be stable while the head is stalled.
REQ-025 SHALL keep count unchanged on simultaneous push and pop; pointers SHALL wrap modulo DEPTH.
REQ-026 SHALL let flush take priority over push and pop: count and pointers go to 0 next cycle, and no wb_en is issued that cycle.
REQ-027 SHALL update flags on pop: fflags[4] |= head invalid; fflags[0] |= head inexact; DZ/OF/UF change only via CSR write.
REQ-028 SHALL, on csr_wr, load fflags <= csr_wdata | (pop flags of the same cycle), so a same-cycle retire is never lost.
REQ-029 SHALL leave fflags unaffected by flush; flushed entries contribute no flags.
REQ-030 SHALL increment retire_cnt by 1 on each pop, wrapping from 16'hFFFF to 0.
REQ-031 SHALL ignore in_valid when in_ready is low; the upstream stage holds its data.

Reset
REQ-032 SHALL, while rst is high, asynchronously force count=0, pointers=0, fflags=0 and retire_cnt=0; in_ready is then 1 and wb_en is 0.
REQ-033 SHALL drop all buffered results and pending flags if rst is asserted mid-operation; no wb_en is issued in the cycle after rst deasserts.

Verification
REQ-034 Single result: push in_float=16'h4A00, rd=3, inexact=0 with wb_stall=0 -> next cycle wb_en=1, wb_addr=3, wb_data=32'hFFFF4A00; retire_cnt=1; fflags=0.
REQ-035 Backpressure: wb_stall=1, push 3 results on consecutive cycles -> first two accepted, in_ready=0 on third; release stall -> two writes in order, then in_ready=1.
REQ-036 Flag accumulate: retire invalid=1, then inexact=1 -> fflags=5'b10001; csr_wr with wdata=0 in the same cycle as a retire of inexact=1 -> fflags=5'b00001.
REQ-037 Flush: 2 entries buffered, flush=1 concurrent with in_valid=1 -> count=0, no wb_en, fflags unchanged, pushed item dropped.
REQ-038 Wrap: 65536 retires -> retire_cnt=0; pointer wrap verified with interleaved push/pop for 10 cycles and data order preserved.
REQ-039 Async reset: assert rst between clock edges with 1 entry buffered -> wb_en=0, fflags=0, in_ready=1 immediately.
